// File: rtl/controller_md.sv
// Decode-stage controller: RV32I main/ALU decode plus RV32M decode
// and a start/stall/valid sequencer for an external mul/div unit.
module controller_md #(
  parameter bit ENABLE_M  = 1'b1,
  parameter int MUL_LAT   = 2,
  parameter int DIV_LAT   = 32,
  parameter bit FAST_DIV0 = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       validD,
  input  logic       flushD,
  input  logic       divzeroD,
  output logic [2:0] ResultSrcD,
  output logic       RegWriteD,
  output logic       MemWriteD,
  output logic       JumpD,
  output logic       BranchD,
  output logic       ALUSrcD,
  output logic [2:0] ImmSrcD,
  output logic       SrcAsrcD,
  output logic [2:0] funct3D,
  output logic       jumpRegD,
  output logic [3:0] ALUControlD,
  output logic       MDStart,
  output logic [2:0] MDOp,
  output logic       MDBusy,
  output logic       MDAbort,
  output logic       StallFD,
  output logic       MDValidD
);

  localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL) + 1;
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] A_ADD  = 4'd0;
  localparam logic [3:0] A_SUB  = 4'd1;
  localparam logic [3:0] A_AND  = 4'd2;
  localparam logic [3:0] A_OR   = 4'd3;
  localparam logic [3:0] A_XOR  = 4'd4;
  localparam logic [3:0] A_SLT  = 4'd5;
  localparam logic [3:0] A_SLTU = 4'd6;
  localparam logic [3:0] A_SLL  = 4'd7;
  localparam logic [3:0] A_SRL  = 4'd8;
  localparam logic [3:0] A_SRA  = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    mdop_q;
  logic          start_q;
  logic          abort_q;

  logic       mdD;
  logic       acceptD;
  logic       div0D;
  logic [1:0] aluop;

  assign mdD     = ENABLE_M && (op == OP_R) && (funct7 == 7'b0000001);
  assign acceptD = validD & mdD & ~flushD;
  assign div0D   = FAST_DIV0 & funct3[2] & divzeroD;
  assign funct3D = funct3;

  always_comb begin
    RegWriteD  = 1'b0;
    ResultSrcD = 3'b000;
    MemWriteD  = 1'b0;
    JumpD      = 1'b0;
    BranchD    = 1'b0;
    ALUSrcD    = 1'b0;
    ImmSrcD    = 3'b000;
    SrcAsrcD   = 1'b0;
    jumpRegD   = 1'b0;
    aluop      = 2'b00;
    unique case (1'b1)
      op == OP_LW: begin
        RegWriteD  = 1'b1;
        ALUSrcD    = 1'b1;
        ResultSrcD = 3'b001;
      end
      op == OP_SW: begin
        MemWriteD = 1'b1;
        ALUSrcD   = 1'b1;
        ImmSrcD   = 3'b001;
      end
      op == OP_R: begin
        RegWriteD = 1'b1;
        aluop     = 2'b10;
      end
      op == OP_B: begin
        BranchD = 1'b1;
        ImmSrcD = 3'b010;
        aluop   = 2'b01;
      end
      op == OP_I: begin
        RegWriteD = 1'b1;
        ALUSrcD   = 1'b1;
        aluop     = 2'b10;
      end
      op == OP_JAL: begin
        RegWriteD  = 1'b1;
        JumpD      = 1'b1;
        ImmSrcD    = 3'b011;
        ResultSrcD = 3'b010;
      end
      op == OP_JALR: begin
        RegWriteD  = 1'b1;
        JumpD      = 1'b1;
        jumpRegD   = 1'b1;
        ALUSrcD    = 1'b1;
        ResultSrcD = 3'b010;
      end
      op == OP_LUI: begin
        RegWriteD  = 1'b1;
        ImmSrcD    = 3'b100;
        ResultSrcD = 3'b011;
      end
      op == OP_AUIPC: begin
        RegWriteD = 1'b1;
        ImmSrcD   = 3'b100;
        ALUSrcD   = 1'b1;
        SrcAsrcD  = 1'b1;
      end
      default: ;
    endcase

    ALUControlD = A_ADD;
    unique case (aluop)
      2'b01: ALUControlD = A_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControlD = (op[5] & funct7[5]) ? A_SUB : A_ADD;
          3'b001:  ALUControlD = A_SLL;
          3'b010:  ALUControlD = A_SLT;
          3'b011:  ALUControlD = A_SLTU;
          3'b100:  ALUControlD = A_XOR;
          3'b101:  ALUControlD = funct7[5] ? A_SRA : A_SRL;
          3'b110:  ALUControlD = A_OR;
          default: ALUControlD = A_AND;
        endcase
      end
      default: ;
    endcase

    // M ops bypass the ALU; writeback comes from the M unit
    if (mdD) begin
      ResultSrcD  = 3'b100;
      ALUControlD = A_ADD;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mdop_q  <= '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (acceptD) begin
            mdop_q <= funct3;
            if (div0D) begin
              state_q <= DONE;
            end else begin
              cnt_q   <= funct3[2] ? DIV_CNT : MUL_CNT;
              state_q <= BUSY;
              start_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (flushD) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            abort_q <= 1'b1;
          end else if (cnt_q == '0) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (flushD) begin
            cnt_q   <= '0;
            abort_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MDStart  = start_q;
  assign MDAbort  = abort_q;
  assign MDOp     = mdop_q;
  assign MDBusy   = (state_q == BUSY);
  assign StallFD  = ((state_q == IDLE) & acceptD)
                  | ((state_q == BUSY) & ~flushD);
  assign MDValidD = (state_q == DONE) & ~flushD;

endmodule

// File: tb/tb_controller_md.sv
// Random + directed bench for controller_md: three configurations
// share one stimulus stream and are checked against a cycle model.
module tb_controller_md;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       validD;
  logic       flushD;
  logic       divzeroD;

  logic [2:0] rs_o[3];
  logic       rw_o[3];
  logic       mw_o[3];
  logic       j_o[3];
  logic       b_o[3];
  logic       as_o[3];
  logic [2:0] is_o[3];
  logic       sa_o[3];
  logic [2:0] f3_o[3];
  logic       jr_o[3];
  logic [3:0] alu_o[3];
  logic       st_o[3];
  logic [2:0] mop_o[3];
  logic       busy_o[3];
  logic       ab_o[3];
  logic       stall_o[3];
  logic       val_o[3];

  localparam bit EN[3] = '{1'b1, 1'b1, 1'b0};
  localparam int ML[3] = '{3, 2, 2};
  localparam int DL[3] = '{8, 8, 32};
  localparam bit FD[3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  controller_md #(.ENABLE_M(EN[0]), .MUL_LAT(ML[0]),
    .DIV_LAT(DL[0]), .FAST_DIV0(FD[0])) u_a (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3),
    .funct7(funct7), .validD(validD), .flushD(flushD),
    .divzeroD(divzeroD), .ResultSrcD(rs_o[0]), .RegWriteD(rw_o[0]),
    .MemWriteD(mw_o[0]), .JumpD(j_o[0]), .BranchD(b_o[0]),
    .ALUSrcD(as_o[0]), .ImmSrcD(is_o[0]), .SrcAsrcD(sa_o[0]),
    .funct3D(f3_o[0]), .jumpRegD(jr_o[0]), .ALUControlD(alu_o[0]),
    .MDStart(st_o[0]), .MDOp(mop_o[0]), .MDBusy(busy_o[0]),
    .MDAbort(ab_o[0]), .StallFD(stall_o[0]), .MDValidD(val_o[0]));

  controller_md #(.ENABLE_M(EN[1]), .MUL_LAT(ML[1]),
    .DIV_LAT(DL[1]), .FAST_DIV0(FD[1])) u_b (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3),
    .funct7(funct7), .validD(validD), .flushD(flushD),
    .divzeroD(divzeroD), .ResultSrcD(rs_o[1]), .RegWriteD(rw_o[1]),
    .MemWriteD(mw_o[1]), .JumpD(j_o[1]), .BranchD(b_o[1]),
    .ALUSrcD(as_o[1]), .ImmSrcD(is_o[1]), .SrcAsrcD(sa_o[1]),
    .funct3D(f3_o[1]), .jumpRegD(jr_o[1]), .ALUControlD(alu_o[1]),
    .MDStart(st_o[1]), .MDOp(mop_o[1]), .MDBusy(busy_o[1]),
    .MDAbort(ab_o[1]), .StallFD(stall_o[1]), .MDValidD(val_o[1]));

  controller_md #(.ENABLE_M(EN[2]), .MUL_LAT(ML[2]),
    .DIV_LAT(DL[2]), .FAST_DIV0(FD[2])) u_c (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3),
    .funct7(funct7), .validD(validD), .flushD(flushD),
    .divzeroD(divzeroD), .ResultSrcD(rs_o[2]), .RegWriteD(rw_o[2]),
    .MemWriteD(mw_o[2]), .JumpD(j_o[2]), .BranchD(b_o[2]),
    .ALUSrcD(as_o[2]), .ImmSrcD(is_o[2]), .SrcAsrcD(sa_o[2]),
    .funct3D(f3_o[2]), .jumpRegD(jr_o[2]), .ALUControlD(alu_o[2]),
    .MDStart(st_o[2]), .MDOp(mop_o[2]), .MDBusy(busy_o[2]),
    .MDAbort(ab_o[2]), .StallFD(stall_o[2]), .MDValidD(val_o[2]));

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // model: remaining busy cycles, done flag, registered pulses
  int         m_left[3];
  bit         m_done[3];
  bit         m_start[3];
  bit         m_abort[3];
  logic [2:0] m_op[3];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit is_md(input int i);
    return EN[i] && op == 7'b0110011 && funct7 == 7'b0000001;
  endfunction

  // {ResultSrc,RegWrite,MemWrite,Jump,Branch,ALUSrc,ImmSrc,
  //  SrcA,funct3,jumpReg,ALUControl}
  function automatic logic [19:0] ref_dec(input int i);
    logic [2:0] rs = 0, is = 0;
    logic rw = 0, mw = 0, j = 0, b = 0, as = 0, sa = 0, jr = 0;
    logic [3:0] alu = 4'd0;
    bit arith = 0;
    case (op)
      7'b0000011: begin rw = 1; as = 1; rs = 3'd1; end
      7'b0100011: begin mw = 1; as = 1; is = 3'd1; end
      7'b0110011: begin rw = 1; arith = 1; end
      7'b1100011: begin b = 1; is = 3'd2; alu = 4'd1; end
      7'b0010011: begin rw = 1; as = 1; arith = 1; end
      7'b1101111: begin rw = 1; j = 1; is = 3'd3; rs = 3'd2; end
      7'b1100111: begin rw = 1; j = 1; jr = 1; as = 1; rs = 3'd2; end
      7'b0110111: begin rw = 1; is = 3'd4; rs = 3'd3; end
      7'b0010111: begin rw = 1; is = 3'd4; as = 1; sa = 1; end
      default: ;
    endcase
    if (arith) begin
      case (funct3)
        3'd0: alu = (op == 7'b0110011 && funct7[5]) ? 4'd1 : 4'd0;
        3'd1: alu = 4'd7;
        3'd2: alu = 4'd5;
        3'd3: alu = 4'd6;
        3'd4: alu = 4'd4;
        3'd5: alu = funct7[5] ? 4'd9 : 4'd8;
        3'd6: alu = 4'd3;
        default: alu = 4'd2;
      endcase
    end
    if (is_md(i)) begin
      rs = 3'd4; alu = 4'd0;
    end
    return {rs, rw, mw, j, b, as, is, sa, funct3, jr, alu};
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      bit idle = (m_left[i] == 0) && !m_done[i];
      bit e_stall = idle ? (validD && is_md(i) && !flushD)
                         : (m_left[i] > 0 ? !flushD : 1'b0);
      check($sformatf("dec%0d", i),
            {rs_o[i], rw_o[i], mw_o[i], j_o[i], b_o[i], as_o[i],
             is_o[i], sa_o[i], f3_o[i], jr_o[i], alu_o[i]},
            ref_dec(i));
      check($sformatf("start%0d", i), st_o[i], m_start[i]);
      check($sformatf("abort%0d", i), ab_o[i], m_abort[i]);
      check($sformatf("mdop%0d", i), mop_o[i], m_op[i]);
      check($sformatf("busy%0d", i), busy_o[i], m_left[i] > 0);
      check($sformatf("stall%0d", i), stall_o[i], e_stall);
      check($sformatf("valid%0d", i), val_o[i],
            m_done[i] && !flushD);
    end
  endtask

  task automatic step_all();
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        m_left[i] = 0; m_done[i] = 0; m_start[i] = 0;
        m_abort[i] = 0; m_op[i] = 0;
      end else if (m_left[i] == 0 && !m_done[i]) begin
        m_start[i] = 0; m_abort[i] = 0;
        if (validD && is_md(i) && !flushD) begin
          m_op[i] = funct3;
          if (FD[i] && funct3[2] && divzeroD) begin
            m_done[i] = 1;
          end else begin
            m_left[i] = funct3[2] ? DL[i] : ML[i];
            m_start[i] = 1;
          end
        end
      end else if (m_left[i] > 0) begin
        m_start[i] = 0;
        if (flushD) begin
          m_left[i] = 0; m_abort[i] = 1;
        end else begin
          m_abort[i] = 0;
          m_left[i]--;
          if (m_left[i] == 0) m_done[i] = 1;
        end
      end else begin
        m_start[i] = 0; m_done[i] = 0; m_abort[i] = flushD;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_on) check_all();
    @(posedge clk);
    step_all();
    chk_on = 1'b1;
    #1;
  endtask

  task automatic drive(input logic [6:0] o, input logic [2:0] f3,
                       input logic [6:0] f7, input logic v,
                       input logic fl, input logic dz,
                       input logic rn, input int n);
    op = o; funct3 = f3; funct7 = f7; validD = v;
    flushD = fl; divzeroD = dz; reset_n = rn;
    for (int k = 0; k < n; k++) tick();
  endtask

  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] M7 = 7'b0000001;

  initial begin
    drive(R, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    drive(R, 3'd0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    drive(R, 3'd0, M7, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    drive(R, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6);
    drive(R, 3'd5, M7, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    drive(R, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 11);
    drive(R, 3'd6, M7, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    drive(R, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    drive(R, 3'd0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    drive(R, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
    drive(R, 3'd0, M7, 1'b1, 1'b0, 1'b0, 1'b1, 4);
    drive(R, 3'd1, M7, 1'b1, 1'b0, 1'b0, 1'b1, 4);
    drive(R, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6);
    drive(R, 3'd4, M7, 1'b1, 1'b0, 1'b0, 1'b1, 5);
    drive(R, 3'd4, M7, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    drive(R, 3'd0, M7, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    drive(R, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 12);

    for (int c = 0; c < 4000; c++) begin
      logic [6:0] o;
      logic [6:0] f7;
      case ($urandom_range(0, 9))
        0: o = 7'b0000011;
        1: o = 7'b0100011;
        2: o = 7'b1100011;
        3: o = 7'b0010011;
        4: o = 7'b1101111;
        5: o = 7'b1100111;
        6: o = 7'b0110111;
        7: o = 7'b0010111;
        8: o = 7'($urandom);
        default: o = R;
      endcase
      case ($urandom_range(0, 3))
        0: f7 = 7'd0;
        1: f7 = 7'b0100000;
        2: f7 = 7'($urandom);
        default: f7 = M7;
      endcase
      drive(o, 3'($urandom), f7, $urandom_range(0, 9) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 63) != 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
